dram_arbiter: RTL and testbench

//  - Two-requester round-robin arbiter/sequencer for the 8x4 D-RAM datapath (clk, wr, add, din, dout).
//  - Sits between requester A/B and the RAM: serialises accesses, drives the RAM write/address/data pins,

---
 rtl/dram_arbiter_if.sv | 46 ++++
 rtl/dram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_arbiter_if.sv
// Requester-side and RAM-side bus of the two-port D-RAM arbiter.
// The arbiter uses the slave view; whatever owns the requesters and the RAM uses the master view.
interface dram_arbiter_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic          a_req;
    logic          a_wr;
    logic [AW-1:0] a_add;
    logic [DW-1:0] a_din;
    logic          a_ack;
    logic          a_rvalid;

    logic          b_req;
    logic          b_wr;
    logic [AW-1:0] b_add;
    logic [DW-1:0] b_din;
    logic          b_ack;
    logic          b_rvalid;

    logic [DW-1:0] rdata;
    logic          busy;

    logic          mem_wr;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  a_req, a_wr, a_add, a_din,
        input  b_req, b_wr, b_add, b_din,
        input  mem_dout,
        output a_ack, a_rvalid, b_ack, b_rvalid,
        output rdata, busy,
        output mem_wr, mem_add, mem_din
    );

    modport master (
        output a_req, a_wr, a_add, a_din,
        output b_req, b_wr, b_add, b_din,
        output mem_dout,
        input  a_ack, a_rvalid, b_ack, b_rvalid,
        input  rdata, busy,
        input  mem_wr, mem_add, mem_din
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter/sequencer placing requesters A and B onto a single 8x4 synchronous-read RAM.
// Define DRAM_REFRESH_EN to add periodic read-then-rewrite refresh cycles every REF_PERIOD clocks.
module dram_arbiter #(
    parameter int DW = 4,
    parameter int AW = 3
`ifdef DRAM_REFRESH_EN
    , parameter int REF_PERIOD = 64
`endif
) (
    input logic           clk,
    input logic           rs,
    dram_arbiter_if.slave bus
);

`ifdef DRAM_REFRESH_EN
    typedef enum logic [2:0] {
        IDLE, ACC, RWAIT, RDAT, RF_RD, RF_WAIT, RF_WR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ACC, RWAIT, RDAT
    } state_t;
`endif

    state_t        state_q, state_d;
    logic          last_b_q, last_b_d;
    logic          owner_b_q, owner_b_d;
    logic          is_wr_q, is_wr_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic          a_rv_q, a_rv_d;
    logic          b_rv_q, b_rv_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_add_q, mem_add_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          grant_b;

`ifdef DRAM_REFRESH_EN
    localparam int            CW       = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REF_PERIOD - 1);

    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic [AW-1:0] ref_addr_q, ref_addr_d;
    logic          ref_pend_q, ref_pend_d;
    logic          ref_wrap;
`endif

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        owner_b_d = owner_b_q;
        is_wr_d   = is_wr_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rv_d    = 1'b0;
        b_rv_d    = 1'b0;
        rdata_d   = rdata_q;
        mem_wr_d  = 1'b0;
        mem_add_d = mem_add_q;
        mem_din_d = mem_din_q;
        grant_b   = 1'b0;
`ifdef DRAM_REFRESH_EN
        ref_wrap   = (ref_cnt_q == CNT_LAST);
        ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + CW'(1);
        ref_addr_d = ref_addr_q;
        ref_pend_d = ref_pend_q | ref_wrap;
`endif

        case (state_q)
            IDLE: begin
`ifdef DRAM_REFRESH_EN
                if (ref_pend_q) begin
                    state_d   = RF_RD;
                    mem_add_d = ref_addr_q;
                end else
`endif
                if (bus.a_req || bus.b_req) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_b   = bus.b_req && (!bus.a_req || !last_b_q);
                    state_d   = ACC;
                    last_b_d  = grant_b;
                    owner_b_d = grant_b;
                    is_wr_d   = grant_b ? bus.b_wr : bus.a_wr;
                    mem_wr_d  = is_wr_d;
                    mem_add_d = grant_b ? bus.b_add : bus.a_add;
                    mem_din_d = grant_b ? bus.b_din : bus.a_din;
                    a_ack_d   = !grant_b;
                    b_ack_d   = grant_b;
                end
            end
            ACC:   state_d = is_wr_q ? IDLE : RWAIT;
            RWAIT: begin
                state_d = RDAT;
                rdata_d = bus.mem_dout;
                a_rv_d  = !owner_b_q;
                b_rv_d  = owner_b_q;
            end
            RDAT:  state_d = IDLE;
`ifdef DRAM_REFRESH_EN
            RF_RD: state_d = RF_WAIT;
            RF_WAIT: begin
                state_d   = RF_WR;
                mem_din_d = bus.mem_dout;
                mem_wr_d  = 1'b1;
            end
            RF_WR: begin
                state_d    = IDLE;
                ref_addr_d = ref_addr_q + AW'(1);
                // A new period expiring in this very cycle must not be lost.
                ref_pend_d = ref_wrap;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            owner_b_q  <= 1'b0;
            is_wr_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rv_q     <= 1'b0;
            b_rv_q     <= 1'b0;
            rdata_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_add_q  <= '0;
            mem_din_q  <= '0;
`ifdef DRAM_REFRESH_EN
            ref_cnt_q  <= '0;
            ref_addr_q <= '0;
            ref_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            owner_b_q  <= owner_b_d;
            is_wr_q    <= is_wr_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rv_q     <= a_rv_d;
            b_rv_q     <= b_rv_d;
            rdata_q    <= rdata_d;
            mem_wr_q   <= mem_wr_d;
            mem_add_q  <= mem_add_d;
            mem_din_q  <= mem_din_d;
`ifdef DRAM_REFRESH_EN
            ref_cnt_q  <= ref_cnt_d;
            ref_addr_q <= ref_addr_d;
            ref_pend_q <= ref_pend_d;
`endif
        end
    end

    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.a_rvalid = a_rv_q;
    assign bus.b_rvalid = b_rv_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_add  = mem_add_q;
    assign bus.mem_din  = mem_din_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed reset/access/contention tests plus a randomized
// cycle-level comparison against a transaction model (refresh checks when DRAM_REFRESH_EN is defined).
module tb_dram_arbiter;
    localparam int DW = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rs  = 1'b0;
    always #5 clk = ~clk;

    dram_arbiter_if #(.DW(DW), .AW(AW)) bus();

    dram_arbiter #(
        .DW(DW), .AW(AW)
`ifdef DRAM_REFRESH_EN
        , .REF_PERIOD(8)
`endif
    ) dut (
        .clk(clk),
        .rs (rs),
        .bus(bus)
    );

    // Synchronous-read 8x4 RAM the arbiter drives.
    logic [DW-1:0] ram [8];
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_add] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_add];
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] ref_mem [8];
    bit            exp_last_b;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic ar, input logic aw, input logic [AW-1:0] aa,
                                 input logic [DW-1:0] ad, input logic br, input logic bw,
                                 input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bus.a_req = ar; bus.a_wr = aw; bus.a_add = aa; bus.a_din = ad;
        bus.b_req = br; bus.b_wr = bw; bus.b_add = ba; bus.b_din = bd;
    endtask

    task automatic resetDut();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rs = 1'b0;
        step();
        step();
        rs = 1'b1;
        exp_last_b = 1'b1;
    endtask

    // Issue one access, wait for its ack, then check read data at ack+2.
    task automatic doAccess(input bit use_b, input bit wr, input logic [AW-1:0] add,
                            input logic [DW-1:0] din);
        bit got;
        got = 1'b0;
        if (use_b) applyStimulus(0, 0, 0, 0, 1, wr, add, din);
        else       applyStimulus(1, wr, add, din, 0, 0, 0, 0);
        for (int n = 0; n < 30 && !got; n++) begin
            step();
            got = use_b ? bus.b_ack : bus.a_ack;
        end
        checkOutput(use_b ? "b_ack_seen" : "a_ack_seen", got, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        if (got) begin
            exp_last_b = use_b;
            checkOutput("ack_other", use_b ? bus.a_ack : bus.b_ack, 0);
            checkOutput("acc_mem_add", bus.mem_add, add);
            checkOutput("acc_mem_wr", bus.mem_wr, wr);
            if (wr) begin
                ref_mem[add] = din;
            end else begin
                step();
                checkOutput("rvalid_early", use_b ? bus.b_rvalid : bus.a_rvalid, 0);
                step();
                checkOutput("rvalid", use_b ? bus.b_rvalid : bus.a_rvalid, 1);
                checkOutput("rvalid_other", use_b ? bus.a_rvalid : bus.b_rvalid, 0);
                checkOutput("rdata", bus.rdata, ref_mem[add]);
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_a_ack"}, bus.a_ack, 0);
        checkOutput({tag, "_b_ack"}, bus.b_ack, 0);
        checkOutput({tag, "_rvalid"}, {bus.a_rvalid, bus.b_rvalid}, 0);
        checkOutput({tag, "_rdata"}, bus.rdata, 0);
        checkOutput({tag, "_mem_wr"}, bus.mem_wr, 0);
        checkOutput({tag, "_mem_add"}, bus.mem_add, 0);
        checkOutput({tag, "_mem_din"}, bus.mem_din, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
    endtask

`ifndef DRAM_REFRESH_EN
    typedef struct {
        bit            a_ack;
        bit            b_ack;
        bit            a_rv;
        bit            b_rv;
        bit            mwr;
        bit            rd_upd;
        logic [DW-1:0] rd;
    } exp_t;

    // Transaction model: the FSM is free from cycle free_at; a write occupies 2 cycles,
    // a read 4; outputs are predicted into a small schedule indexed by cycle.
    task automatic runRandom(input int n_cycles);
        exp_t          sched [8];
        int            free_at;
        logic [DW-1:0] m_rdata;
        bit            a_hold, b_hold, a_w, b_w, win_b, w;
        logic [AW-1:0] a_a, b_a, ad;
        logic [DW-1:0] a_d, b_d;
        exp_t          e;
        int            s;
        for (int i = 0; i < 8; i++) sched[i] = '{default: '0};
        free_at = cyc;
        m_rdata = '0;
        a_hold = 0; b_hold = 0; a_w = 0; b_w = 0;
        a_a = '0; b_a = '0; a_d = '0; b_d = '0;
        for (int k = 0; k < n_cycles; k++) begin
            if (!a_hold && $urandom_range(0, 1) == 1) begin
                a_hold = 1; a_w = 1'($urandom); a_a = AW'($urandom); a_d = DW'($urandom);
            end
            if (!b_hold && $urandom_range(0, 1) == 1) begin
                b_hold = 1; b_w = 1'($urandom); b_a = AW'($urandom); b_d = DW'($urandom);
            end
            applyStimulus(a_hold, a_w, a_a, a_d, b_hold, b_w, b_a, b_d);
            if (cyc >= free_at && (a_hold || b_hold)) begin
                win_b      = b_hold && (!a_hold || !exp_last_b);
                exp_last_b = win_b;
                w          = win_b ? b_w : a_w;
                ad         = win_b ? b_a : a_a;
                s          = (cyc + 1) % 8;
                sched[s].a_ack = !win_b;
                sched[s].b_ack = win_b;
                sched[s].mwr   = w;
                if (w) begin
                    ref_mem[ad] = win_b ? b_d : a_d;
                    free_at     = cyc + 2;
                end else begin
                    s = (cyc + 3) % 8;
                    sched[s].a_rv   = !win_b;
                    sched[s].b_rv   = win_b;
                    sched[s].rd_upd = 1;
                    sched[s].rd     = ref_mem[ad];
                    free_at         = cyc + 4;
                end
                if (win_b) b_hold = 0;
                else       a_hold = 0;
            end
            step();
            s = cyc % 8;
            e = sched[s];
            if (e.rd_upd) m_rdata = e.rd;
            checkOutput("rnd_a_ack", bus.a_ack, e.a_ack);
            checkOutput("rnd_b_ack", bus.b_ack, e.b_ack);
            checkOutput("rnd_a_rvalid", bus.a_rvalid, e.a_rv);
            checkOutput("rnd_b_rvalid", bus.b_rvalid, e.b_rv);
            checkOutput("rnd_mem_wr", bus.mem_wr, e.mwr);
            checkOutput("rnd_rdata", bus.rdata, m_rdata);
            checkOutput("rnd_busy", bus.busy, (cyc < free_at) ? 1 : 0);
            sched[s] = '{default: '0};
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
`else
    // Watch for refresh rewrites (mem_wr with no ack) and verify address order and data.
    task automatic watchRefresh(input int n_cycles, input bit hold_b, inout logic [AW-1:0] rf_addr,
                                output int rf_count);
        logic [DW-1:0] bd;
        bd = 4'h9;
        rf_count = 0;
        for (int k = 0; k < n_cycles; k++) begin
            if (hold_b) applyStimulus(0, 0, 0, 0, 1, 1, 3'd4, bd);
            step();
            if (bus.b_ack) begin
                ref_mem[4] = bd;
                bd = bd + 4'd1;
            end else if (bus.mem_wr) begin
                checkOutput("rf_mem_add", bus.mem_add, rf_addr);
                checkOutput("rf_mem_din", bus.mem_din, ref_mem[rf_addr]);
                checkOutput("rf_no_ack", {bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid}, 0);
                rf_addr = rf_addr + 3'd1;
                rf_count++;
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] fill_vals [8];
        int            grants;
        bit            got;
        logic [DW-1:0] ca, cb;

        fill_vals = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h1, 4'h8, 4'hF, 4'h0};

        // Reset held two cycles with A requesting: nothing may leak out.
        applyStimulus(1, 1, 3'b010, 4'b0011, 0, 0, 0, 0);
        rs = 1'b0;
        step();
        checkResetOutputs("rst1");
        step();
        checkResetOutputs("rst2");
        rs = 1'b1;
        exp_last_b = 1'b1;
        step();
        checkOutput("first_a_ack", bus.a_ack, 1);
        checkOutput("first_mem_wr", bus.mem_wr, 1);
        checkOutput("first_mem_add", bus.mem_add, 3'b010);
        checkOutput("first_mem_din", bus.mem_din, 4'b0011);
        checkOutput("first_busy", bus.busy, 1);
        ref_mem[2] = 4'b0011;
        exp_last_b = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("first_ack_pulse", bus.a_ack, 0);
        checkOutput("first_mem_wr_pulse", bus.mem_wr, 0);
        doAccess(0, 0, 3'b010, 4'h0);

        // Fill through B, read back through A.
        for (int i = 0; i < 8; i++) doAccess(1, 1, AW'(i), fill_vals[i]);
        for (int i = 0; i < 8; i++) doAccess(0, 0, AW'(i), 4'h0);

        // Continuous contention after reset: A, B, A, B ...
        resetDut();
        ca = 4'h1;
        cb = 4'h6;
        grants = 0;
        applyStimulus(1, 1, 3'd6, ca, 1, 1, 3'd7, cb);
        for (int n = 0; n < 60 && grants < 8; n++) begin
            step();
            checkOutput("cont_ack_both", bus.a_ack & bus.b_ack, 0);
            if (bus.a_ack || bus.b_ack) begin
                checkOutput("cont_rr_winner", bus.b_ack, !exp_last_b);
                exp_last_b = !exp_last_b;
                if (exp_last_b) begin ref_mem[7] = cb; cb = cb + 4'd1; end
                else            begin ref_mem[6] = ca; ca = ca + 4'd1; end
                applyStimulus(1, 1, 3'd6, ca, 1, 1, 3'd7, cb);
                grants++;
            end
        end
        checkOutput("cont_grants", grants, 8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        doAccess(0, 0, 3'd6, 4'h0);
        doAccess(1, 0, 3'd7, 4'h0);

        // Reset asserted while a read sits in RWAIT: its rvalid must never appear.
        got = 1'b0;
        applyStimulus(1, 0, 3'd1, 4'h0, 0, 0, 0, 0);
        for (int n = 0; n < 30 && !got; n++) begin
            step();
            got = bus.a_ack;
        end
        checkOutput("midrd_ack_seen", got, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rs = 1'b0;
        step();
        checkOutput("midrd_rvalid_rst", bus.a_rvalid, 0);
        checkOutput("midrd_busy_rst", bus.busy, 0);
        rs = 1'b1;
        exp_last_b = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            checkOutput("midrd_rvalid_after", bus.a_rvalid, 0);
        end
        doAccess(0, 0, 3'd1, 4'h0);

`ifndef DRAM_REFRESH_EN
        resetDut();
        runRandom(400);
`else
        begin
            logic [AW-1:0] rf_addr;
            int            rf_count;
            resetDut();
            rf_addr = '0;
            watchRefresh(80, 1'b0, rf_addr, rf_count);
            checkOutput("rf_idle_count", (rf_count >= 9) ? 1 : 0, 1);
            watchRefresh(48, 1'b1, rf_addr, rf_count);
            checkOutput("rf_busy_count", (rf_count >= 4) ? 1 : 0, 1);
            for (int i = 0; i < 8; i++) doAccess(0, 0, AW'(i), 4'h0);
        end
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
